pipe_skid_stage: RTL
====================

# pipe_skid_stage

Parametrised pipeline stage register that replaces the fixed per-stage latches between CPU pipeline stages. It carries a generic data payload and a control payload under a valid/ready handshake. A two-entry skid buffer gives full throughput while keeping `in_ready` registered. The block also adds a synchronous flush that kills in-flight control side effects (regwrite, memwrite, jmp, and so on), and saturating stall/bubble counters for performance analysis.

## Interface
- `DATA_W`, default 64: width of the data payload (register operands, immediates, PC).
- `CTRL_W`, default 16: width of the control payload. It is zeroed whenever the stage holds no valid beat.
- `CNT_W`, default 16: width of each performance counter.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat; registered.
- `in_data`  in  DATA_W  upstream data payload.
- `in_ctrl`  in  CTRL_W  upstream control payload.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  downstream data payload.
- `out_ctrl`  out  CTRL_W  downstream control payload; zero when `out_valid` is 0.
- `flush`  in  1  synchronous kill of every held beat and of any beat offered this cycle.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `occupancy`  out  2  number of held beats: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0; saturating.
- `bubble_cnt`  out  CNT_W  cycles with `out_valid`=0 and `out_ready`=1; saturating.

## Operation
- Storage consists of a main register (drives the outputs) and a skid register (holds data, ctrl and a valid bit).
- Handshakes:
  - An input handshake is `in_valid & in_ready`.
  - An output handshake is `out_valid & out_ready`.
- Next-cycle value of `in_ready` is `!skid_valid_next`.
- State is encoded by occupancy: EMPTY (0), ONE (1), FULL (2).
- Transitions, evaluated when `flush` is 0:
  - EMPTY: if an input beat arrives, load main; go to ONE. Otherwise stay EMPTY.
  - ONE, input and output handshakes in the same cycle: load main from input; stay ONE.
  - ONE, input handshake only: load skid from input; go to FULL.
  - ONE, output handshake only: go to EMPTY; clear `out_ctrl` to 0.
  - ONE, neither handshake: hold.
  - FULL, output handshake: move skid into main; go to ONE. No input is accepted in FULL because `in_ready` is 0.
  - FULL, no output handshake: hold.
- Flush:
  - `flush`=1 has highest priority over every transition.
  - The next state is EMPTY: main valid and skid valid clear, `out_ctrl` and the skid ctrl clear to 0, `in_ready`=1.
  - Any input beat offered in the flush cycle is discarded, even if `in_ready` was 1.
  - `out_data` holds its last value.
- Data hygiene:
  - `out_data` changes only when main loads.
  - `out_ctrl` is 0 in every cycle where `out_valid` is 0.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1; it never wraps.
  - `cnt_clr` forces both counters to 0. It takes priority over the increment in the same cycle.
  - The counters keep counting during flush cycles, based on pre-flush output values.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 beat/cycle when `out_ready` stays high.
- Backpressure:
  - `out_ready` low for one cycle while in ONE fills the skid.
  - `in_ready` falls after that same edge.
  - `in_ready` has no combinational path from `out_ready`.
- Reset values, applied asynchronously on `rst`=1:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=0.
  - skid cleared.
  - `occupancy`=0.
  - `stall_cnt`=0, `bubble_cnt`=0.
  - `in_ready`=0.
- After reset:
  - `in_ready` rises at the first rising edge after `rst` deasserts.
  - No beat is accepted in the cycle in which `in_ready` is still 0.
- Reset mid-operation: held beats are lost and all outputs return immediately to their reset values.
- Simultaneous `flush` and `cnt_clr`: both take effect in the same edge.

## Test plan
- **Streaming.** After reset, drive beats with data 0x11, 0x22, 0x33 and ctrl 0x0001 on consecutive cycles, with `out_ready`=1. Required: the same three beats appear one cycle later in order, `occupancy` is 1 throughout, and `in_ready` never drops.
- **Skid.** Hold `out_ready`=0 with `in_valid`=1. Required: beats A and B are accepted, `occupancy` reaches 2, and `in_ready`=0 on the next cycle. Then raise `out_ready`. Required: A, then B are delivered, and `in_ready` returns to 1 after A leaves.
- **Flush in FULL.** Flush while holding two beats, with `in_valid`=1. Required: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0 and `in_ready`=1, and the offered beat never appears.
- **Reset.** Assert `rst` asynchronously between edges while in FULL. Required: all outputs go to reset values at once, and `in_ready` is 1 only after the first edge following deassertion.
- **Counters.** Use CNT_W=4 and hold `out_valid`=1 with `out_ready`=0 for 20 cycles. Required: `stall_cnt` saturates at 15. Then pulse `cnt_clr` in a stall cycle. Required: `stall_cnt` reads 0, then increments to 1 on the next stall cycle.
- **Bubbles.** Run 5 idle cycles with `out_ready`=1. Required: `bubble_cnt`=5 and `out_ctrl` stays at 0.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream (in_*) and downstream (out_*) sides.
// slave is the stage's view; master is the view of the surrounding pipeline.
interface pipe_skid_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_ctrl,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ctrl
  );

  modport master (
    output in_valid,
    output in_data,
    output in_ctrl,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ctrl
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer, registered in_ready, synchronous flush
// and saturating stall/bubble performance counters.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_skid_stage_if.slave     bus,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic main_valid;
  logic in_hs;
  logic out_hs;

  assign main_valid = (state_q != StEmpty);
  // in_ready is the registered copy, so acceptance never depends on out_ready combinationally.
  assign in_hs      = bus.in_valid & in_ready_q;
  assign out_hs     = main_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      // Kill held beats and any beat offered now; out_data keeps its last value.
      state_d      = StEmpty;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
      skid_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_hs) begin
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_hs && out_hs) begin
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
          end else if (in_hs) begin
            skid_data_d  = bus.in_data;
            skid_ctrl_d  = bus.in_ctrl;
            skid_valid_d = 1'b1;
            state_d      = StFull;
          end else if (out_hs) begin
            main_ctrl_d = '0;
            state_d     = StEmpty;
          end
        end
        StFull: begin
          if (out_hs) begin
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            state_d      = StOne;
          end
        end
        default: begin
          state_d      = StEmpty;
          main_ctrl_d  = '0;
          skid_ctrl_d  = '0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = ~skid_valid_d;
  end

  // Counters look at the current (pre-flush) outputs; clear wins over increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (main_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (!main_valid && bus.out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule
